// File: rtl/sift_pkg.sv
// Shared definitions for the sifting-stage ping-pong buffer: bank life-cycle
// states and the channel slot assignment inside a stored word.
package sift_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int CH_ALICE = 0;
  localparam int CH_BOB   = 1;

endpackage

// File: rtl/sift_dp_bram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The read register holds its value whenever re_i is low.
module sift_dp_bram #(
  parameter int WIDTH = 2,
  parameter int AW    = 11
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sift_pingpong_mem.sv
// Two-bank ping-pong buffer between raw-detection capture and the sifting
// comparator. Optional early block close via `define SIFT_MEM_FLUSH_EN.
//
// Handshakes: a word moves on a port exactly on a rising edge where valid and
// ready are both high; valid never depends on ready, and rd_data/rd_last/
// rd_bank hold while rd_valid is high and rd_ready is low.
module sift_pingpong_mem
  import sift_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef SIFT_MEM_FLUSH_EN
  input  logic                       flush,
`endif
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [NUM_CH*DATA_W-1:0]   wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [NUM_CH*DATA_W-1:0]   rd_data,
  output logic                       rd_last,
  output logic                       rd_bank,
  output logic [$clog2(DEPTH):0]     blk_len
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int WORD_W = NUM_CH * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  // Per-bank life cycle; hierarchical checkers can bind to st_q directly.
  bank_state_t       st_q [2];
  bank_state_t       st_d [2];
  logic [ADDR_W:0]   len_q [2];
  logic [ADDR_W:0]   len_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              rd_sel_q, rd_sel_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   blk_len_q, blk_len_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic              rd_bank_q, rd_bank_d;

  logic              flush_w;
  logic              wr_accept;
  logic [ADDR_W:0]   wr_fill;
  logic              wr_close;
  logic              draining;
  logic              drain_start;
  logic              rd_adv;
  logic              rd_issue;
  logic              rd_free;

`ifdef SIFT_MEM_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // wr_fill counts the word accepted this cycle, so a flush on that cycle keeps it.
  assign wr_accept   = wr_valid && wr_ready;
  assign wr_fill     = {1'b0, wr_ptr_q} + {{ADDR_W{1'b0}}, wr_accept};
  assign wr_close    = (wr_accept && (wr_ptr_q == LAST_PTR)) ||
                       (flush_w && wr_ready && (wr_fill != '0));
  assign draining    = (st_q[rd_sel_q] == DRAINING);
  assign drain_start = (st_q[rd_sel_q] == FULL);
  assign rd_adv      = !rd_valid_q || rd_ready;
  assign rd_issue    = draining && (rd_cnt_q != blk_len_q) && rd_adv;
  assign rd_free     = rd_valid_q && rd_ready && rd_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q[0]    <= FILLING;
      st_q[1]    <= EMPTY;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_sel_q   <= 1'b0;
      rd_cnt_q   <= '0;
      blk_len_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_sel_q   <= rd_sel_d;
      rd_cnt_q   <= rd_cnt_d;
      blk_len_q  <= blk_len_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    rd_sel_d   = rd_sel_q;
    rd_cnt_d   = rd_cnt_q;
    blk_len_d  = blk_len_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_bank_d  = rd_bank_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;

    if (rd_free) begin
      st_d[rd_sel_q] = EMPTY;
      rd_sel_d       = ~rd_sel_q;
    end

    if (wr_close) begin
      st_d[wr_bank_q]  = FULL;
      len_d[wr_bank_q] = wr_fill;
      wr_bank_d        = ~wr_bank_q;
      wr_ptr_d         = '0;
    end

    // The writer's target bank starts filling the moment it is free, which
    // covers both the immediate switch and the release by a final read.
    if (st_d[wr_bank_d] == EMPTY) st_d[wr_bank_d] = FILLING;

    if (drain_start) begin
      st_d[rd_sel_q] = DRAINING;
      blk_len_d      = len_q[rd_sel_q];
      rd_cnt_d       = '0;
    end

    if (rd_adv) begin
      rd_valid_d = rd_issue;
      rd_last_d  = rd_issue && (rd_cnt_q == blk_len_q - 1'b1);
      if (rd_issue) rd_bank_d = rd_sel_q;
    end

    if (rd_issue) rd_cnt_d = rd_cnt_q + 1'b1;
  end

  always_comb begin
    wr_ready = (st_q[wr_bank_q] == FILLING);
    rd_valid = rd_valid_q;
    rd_last  = rd_last_q;
    rd_bank  = rd_bank_q;
    blk_len  = blk_len_q;
  end

  sift_dp_bram #(
    .WIDTH (WORD_W),
    .AW    (ADDR_W + 1)
  ) u_bram (
    .clk_i   (clk),
    .we_i    (wr_accept),
    .waddr_i ({wr_bank_q, wr_ptr_q}),
    .wdata_i (wr_data),
    .re_i    (rd_issue),
    .raddr_i ({rd_sel_q, rd_cnt_q[ADDR_W-1:0]}),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_sift_pingpong_mem.sv
// Bench for sift_pingpong_mem: random producer/consumer traffic checked by a
// block-level reference model and an expected-word queue.
module tb_sift_pingpong_mem;

  localparam int DATA_W = 1;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 1024;
  localparam int AW     = $clog2(DEPTH);
  localparam int W      = NUM_CH * DATA_W;
  localparam int EW     = (AW + 1) + 1 + 1 + W;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [W-1:0]  wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [W-1:0]  rd_data;
  logic          rd_last;
  logic          rd_bank;
  logic [AW:0]   blk_len;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_total = 0;
  logic rd_rand = 1'b0;
  logic rd_fixed = 1'b1;

  // Expected entry: {blk_len, rd_bank, rd_last, rd_data}
  logic [EW-1:0] exp_q [$];
  logic [W-1:0]  pend_q [$];
  logic          mdl_bank;

  sift_pingpong_mem #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef SIFT_MEM_FLUSH_EN
    .flush    (flush),
`endif
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_bank  (rd_bank),
    .blk_len  (blk_len)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    wr_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- drivers ----------------
  initial begin
    rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : rd_fixed;
    end
  end

  function automatic logic [W-1:0] gen(input int pat, input int i);
    if (pat == 0) return W'(i % 4);
    return W'($urandom);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Presents n words; a presented word is held until accepted.
  task automatic write_words(input int n, input int pat, input int vprob, output int acc_cyc);
    int   done;
    int   budget;
    logic pend;
    done = 0;
    budget = 0;
    pend = 1'b0;
    acc_cyc = 0;
    while (done < n && budget < n * 8 + 4000) begin
      @(posedge clk); #1;
      if (!pend) begin
        wr_data = gen(pat, done);
        pend = ($urandom_range(0, 99) < vprob);
      end
      wr_valid = pend;
      @(negedge clk);
      budget++;
      if (wr_valid && wr_ready) begin
        done++;
        pend = 1'b0;
        acc_cyc = cyc + 1;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("write_done", done, n);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < DEPTH * 6 + 200) begin
      @(negedge clk);
      budget++;
    end
    repeat (8) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- reference model ----------------
  // Accepted words are grouped into blocks (full DEPTH or flushed); each
  // closed block is expected on alternating banks in fill order.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      mdl_bank = 1'b0;
    end else begin
      if (wr_valid && wr_ready) pend_q.push_back(wr_data);
      if (pend_q.size() == DEPTH || (flush && wr_ready && pend_q.size() != 0)) begin
        for (int i = 0; i < pend_q.size(); i++) begin
          logic [AW:0] l;
          logic        last;
          l = (AW + 1)'(pend_q.size());
          last = (i == pend_q.size() - 1);
          exp_q.push_back({l, mdl_bank, last, pend_q[i]});
        end
        pend_q.delete();
        mdl_bank = ~mdl_bank;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic         stall_prev = 1'b0;
  logic [W+1:0] stall_val;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_cmp++;
        if (!rd_valid || {rd_data, rd_last, rd_bank} != stall_val) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", rd_valid,
                   {rd_data, rd_last, rd_bank}, stall_val);
        end
      end
      if (rd_valid && rd_ready) begin
        hs_total++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got data=%h last=%0b bank=%0b required no word",
                   rd_data, rd_last, rd_bank);
        end else begin
          logic [EW-1:0] e;
          logic [EW-1:0] got;
          e = exp_q.pop_front();
          got = {blk_len, rd_bank, rd_last, rd_data};
          if (got != e) begin
            n_err++;
            $display("FAIL read_word: got len=%0d bank=%0b last=%0b data=%h required len=%0d bank=%0b last=%0b data=%h",
                     got[EW-1 -: AW+1], got[W+1], got[W], got[W-1:0],
                     e[EW-1 -: AW+1], e[W+1], e[W], e[W-1:0]);
          end
        end
      end
      stall_prev = rd_valid && !rd_ready;
      stall_val = {rd_data, rd_last, rd_bank};
    end
  end

  // ---------------- tests ----------------
  initial begin
    int acc_cyc;
    int first_cyc;
    int base;
    int found;
    int seen;
    rst = 1'b1;
    flush = 1'b0;
    wr_valid = 1'b0;
    wr_data = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_last", int'(rd_last), 0);
    chk("rst_rd_bank", int'(rd_bank), 0);
    chk("rst_blk_len", int'(blk_len), 0);

    // One full block, pattern i%4, latency from final write to first rd_valid
    rd_fixed = 1'b1;
    write_words(DEPTH, 0, 100, acc_cyc);
    first_cyc = -1;
    for (int i = 0; i < 20 && first_cyc < 0; i++) begin
      @(negedge clk);
      if (rd_valid) first_cyc = cyc;
    end
    chk("first_rd_latency", first_cyc - acc_cyc, 2);
    wait_drain("drain_block0");

    // Continuous stream over three blocks (banks 0,1,0)
    do_reset();
    write_words(3 * DEPTH, 1, 100, acc_cyc);
    wait_drain("drain_stream");

    // Both banks filled with the reader stalled
    do_reset();
    rd_fixed = 1'b0;
    write_words(2 * DEPTH, 1, 100, acc_cyc);
    @(negedge clk);
    chk("wr_ready_both_full", int'(wr_ready), 0);
    repeat (10) @(negedge clk);
    rd_fixed = 1'b1;
    found = 0;
    for (int i = 0; i < DEPTH + 100 && found == 0; i++) begin
      @(negedge clk);
      if (rd_valid && rd_ready && rd_last) found = 1;
    end
    chk("last_hs_found", found, 1);
    chk("wr_ready_at_last_hs", int'(wr_ready), 0);
    @(negedge clk);
    chk("wr_ready_after_last_hs", int'(wr_ready), 1);
    wait_drain("drain_two_banks");

    // Random consumer backpressure and producer gaps
    do_reset();
    rd_rand = 1'b1;
    write_words(DEPTH, 1, 70, acc_cyc);
    wait_drain("drain_random_ready");
    write_words(DEPTH, 1, 60, acc_cyc);
    wait_drain("drain_random_ready2");
    rd_rand = 1'b0;
    rd_fixed = 1'b1;

    // Reset in the middle of a drain
    do_reset();
    base = hs_total;
    write_words(DEPTH, 1, 100, acc_cyc);
    for (int i = 0; i < DEPTH && (hs_total - base) < 500; i++) @(negedge clk);
    chk("midreset_progress", hs_total - base, 500);
    do_reset();
    @(negedge clk);
    chk("midreset_rd_valid", int'(rd_valid), 0);
    chk("midreset_wr_ready", int'(wr_ready), 1);
    chk("midreset_rd_bank", int'(rd_bank), 0);
    write_words(DEPTH, 0, 100, acc_cyc);
    wait_drain("drain_after_reset");

`ifdef SIFT_MEM_FLUSH_EN
    // Partial block closed by flush, then an empty flush, then a full block
    do_reset();
    write_words(300, 0, 100, acc_cyc);
    pulse_flush();
    wait_drain("drain_flush300");
    pulse_flush();
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rd_valid) seen++;
    end
    chk("empty_flush_no_block", seen, 0);
    write_words(DEPTH, 1, 100, acc_cyc);
    wait_drain("drain_after_empty_flush");
    // Flush on the same cycle as an accepted write keeps that word
    write_words(3, 1, 100, acc_cyc);
    @(posedge clk); #1;
    wr_data = W'($urandom);
    wr_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    flush = 1'b0;
    wait_drain("drain_flush_with_write");
`else
    seen = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
